// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge.
// Holds bus widths, the NOP encoding and the fetch FSM state encodings.
package inst_fetch_bridge_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] NopInst  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FetchIdle = 2'd0,
        FetchReq  = 2'd1,
        FetchWait = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: serves the core's combinational ROM port from a
// one-word buffer and refills it over a request/acknowledge read bus. Misses
// raise stall_req_o until the word lands in the buffer.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              stall_req_o,
    output logic              addr_err_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic              bus_ack_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_err_i
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic              buf_vld;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    logic hit;
    logic miss;
    logic misaligned;
    logic start_fetch;
    logic fill;

    assign hit         = rom_ce_i && buf_vld && (buf_addr == rom_addr_i);
    assign miss        = rom_ce_i && !hit;
    assign misaligned  = (rom_addr_i[1:0] != 2'b00);
    assign start_fetch = (state_q == FetchIdle) && miss && !misaligned;
    assign fill        = (state_q == FetchWait) && bus_rvalid_i;

    // State register; reset drops any request in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FetchIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a started request always runs to completion regardless of the core.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FetchIdle: if (start_fetch)  state_d = FetchReq;
            FetchReq:  if (bus_ack_i)    state_d = FetchWait;
            FetchWait: if (bus_rvalid_i) state_d = FetchIdle;
            default:                     state_d = FetchIdle;
        endcase
    end

    // Core-facing outputs: data only on a hit in IDLE, stall only while the core is fetching.
    always_comb begin
        stall_req_o = 1'b0;
        rom_data_o  = DATA_W'(NopInst);
        case (state_q)
            FetchIdle: begin
                if (hit) begin
                    rom_data_o = buf_data;
                end else if (start_fetch) begin
                    stall_req_o = 1'b1;
                end
            end
            default: stall_req_o = rom_ce_i;
        endcase
    end

    // Bus request, error pulses and buffer refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_o  <= 1'b0;
            bus_addr_o <= ADDR_W'(ZeroWord);
            addr_err_o <= 1'b0;
            bus_err_o  <= 1'b0;
            buf_vld    <= 1'b0;
            buf_addr   <= ADDR_W'(ZeroWord);
            buf_data   <= DATA_W'(NopInst);
        end else begin
            bus_req_o  <= (state_d == FetchReq);
            addr_err_o <= (state_q == FetchIdle) && miss && misaligned;
            bus_err_o  <= fill && bus_err_i;
            if (start_fetch) begin
                bus_addr_o <= rom_addr_i;
            end
            if (fill) begin
                buf_vld  <= 1'b1;
                buf_addr <= bus_addr_o;
                buf_data <= bus_err_i ? DATA_W'(NopInst) : bus_rdata_i;
            end
        end
    end

endmodule
